// File: rtl/eth_test_pkg.sv
// ---------------------------------------------------------------------------
// eth_test_pkg
// Shared types and constants for the Ethernet test-frame generator and the
// companion RX frame checker.
//   MIN_FRAME_LEN / MAX_FRAME_LEN : legal frame length range (bytes, no FCS)
//   HDR_LEN                       : DST + SRC + ethertype + 32-bit sequence
//   byte_idx_t                    : byte position within a frame
//   state_e                       : generator FSM states
//   clamp_len()                   : forces a requested length into range
// ---------------------------------------------------------------------------
package eth_test_pkg;

    localparam int unsigned MIN_FRAME_LEN = 60;
    localparam int unsigned MAX_FRAME_LEN = 1514;
    localparam int unsigned HDR_LEN       = 18;
    localparam int unsigned IDX_W         = 11;

    typedef logic [IDX_W-1:0] byte_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        GAP,
        DONE
    } state_e;

    function automatic byte_idx_t clamp_len(input byte_idx_t len);
        byte_idx_t res;
        if (len < byte_idx_t'(MIN_FRAME_LEN)) begin
            res = byte_idx_t'(MIN_FRAME_LEN);
        end else if (len > byte_idx_t'(MAX_FRAME_LEN)) begin
            res = byte_idx_t'(MAX_FRAME_LEN);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/eth_hdr_byte_sel.sv
// ---------------------------------------------------------------------------
// eth_hdr_byte_sel
// Combinational header byte mux: maps a header byte index 0..17 and the
// frame sequence number to the byte on the wire. Shared with the RX checker.
//   idx_i  : byte index within the frame (only 0..17 are meaningful)
//   seq_i  : 32-bit sequence number, sent big-endian in bytes 14..17
//   byte_o : header byte, 0 for indices outside the header
// ---------------------------------------------------------------------------
module eth_hdr_byte_sel
    import eth_test_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
    input  byte_idx_t   idx_i,
    input  logic [31:0] seq_i,
    output logic [7:0]  byte_o
);

    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            11'd0:   byte_o = DST_MAC[47:40];
            11'd1:   byte_o = DST_MAC[39:32];
            11'd2:   byte_o = DST_MAC[31:24];
            11'd3:   byte_o = DST_MAC[23:16];
            11'd4:   byte_o = DST_MAC[15:8];
            11'd5:   byte_o = DST_MAC[7:0];
            11'd6:   byte_o = SRC_MAC[47:40];
            11'd7:   byte_o = SRC_MAC[39:32];
            11'd8:   byte_o = SRC_MAC[31:24];
            11'd9:   byte_o = SRC_MAC[23:16];
            11'd10:  byte_o = SRC_MAC[15:8];
            11'd11:  byte_o = SRC_MAC[7:0];
            11'd12:  byte_o = ETH_TYPE[15:8];
            11'd13:  byte_o = ETH_TYPE[7:0];
            11'd14:  byte_o = seq_i[31:24];
            11'd15:  byte_o = seq_i[23:16];
            11'd16:  byte_o = seq_i[15:8];
            11'd17:  byte_o = seq_i[7:0];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/eth_test_frame_gen.sv
// ---------------------------------------------------------------------------
// eth_test_frame_gen
// Ethernet test-frame generator feeding the user-side TX stream of the GMII
// MAC. Frames carry DST/SRC MAC, ethertype, a big-endian sequence number and
// an incrementing payload (byte at frame index i = i[7:0]). FCS and preamble
// are added downstream by the MAC.
//   i_sys_clk, i_sys_rst_n : clock, async active-low reset
//   i_enable               : run request (level)
//   i_frame_len            : frame length in bytes, clamped to 60..1514
//   i_gap                  : idle cycles between frames
//   i_num_frames           : frames to send, 0 = continuous
//   o_tx_data/valid/last   : byte stream to MAC, i_tx_ready is the MAC accept
//   o_busy, o_done         : status
//   o_frame_cnt            : frames completed since start (saturating)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for i_enable; no output
// HDR     | sending header bytes 0..17
// PAYLOAD | sending incrementing payload up to len-1
// GAP     | idle cycles between frames, down-counter from i_gap
// DONE    | requested frame count reached; waits for i_enable low
// ---------------------------------------------------------------------------
module eth_test_frame_gen
    import eth_test_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [15:0] ETH_TYPE = 16'h88B5,
    parameter int unsigned GAP_W    = 16
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst_n,
    input  logic              i_enable,
    input  logic [10:0]       i_frame_len,
    input  logic [GAP_W-1:0]  i_gap,
    input  logic [31:0]       i_num_frames,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic              o_tx_last,
    input  logic              i_tx_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_frame_cnt
);

    state_e           state_q, state_d;
    byte_idx_t        idx_q, idx_d;
    byte_idx_t        len_q, len_d;
    logic [31:0]      seq_q, seq_d;
    logic [31:0]      frame_cnt_q, frame_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             tx_valid;
    logic             beat;
    logic             is_last;
    logic [31:0]      cnt_inc;
    logic [7:0]       hdr_byte;

    eth_hdr_byte_sel #(
        .DST_MAC  (DST_MAC),
        .SRC_MAC  (SRC_MAC),
        .ETH_TYPE (ETH_TYPE)
    ) u_hdr_sel (
        .idx_i  (idx_q),
        .seq_i  (seq_q),
        .byte_o (hdr_byte)
    );

    // All outputs are decoded from registers, so the async reset clears
    // them without waiting for a clock edge, and they are held while stalled.
    assign tx_valid = (state_q == HDR) || (state_q == PAYLOAD);
    assign beat     = tx_valid && i_tx_ready;
    assign is_last  = (state_q == PAYLOAD) && (idx_q == byte_idx_t'(len_q - byte_idx_t'(1)));
    assign cnt_inc  = (frame_cnt_q == 32'hFFFF_FFFF) ? frame_cnt_q : frame_cnt_q + 32'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d     = HDR;
                    idx_d       = '0;
                    len_d       = clamp_len(i_frame_len);
                    seq_d       = '0;
                    frame_cnt_d = '0;
                end
            end

            HDR: begin
                if (beat) begin
                    idx_d = idx_q + byte_idx_t'(1);
                    if (idx_q == byte_idx_t'(HDR_LEN - 1)) begin
                        state_d = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (beat) begin
                    if (is_last) begin
                        frame_cnt_d = cnt_inc;
                        seq_d       = seq_q + 32'd1;
                        idx_d       = '0;
                        if ((i_num_frames != 32'd0) && (cnt_inc == i_num_frames)) begin
                            state_d = DONE;
                        end else if (!i_enable) begin
                            state_d = IDLE;
                        end else if (i_gap == '0) begin
                            // back-to-back: next header follows with no idle cycle
                            state_d = HDR;
                            len_d   = clamp_len(i_frame_len);
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = i_gap;
                        end
                    end else begin
                        idx_d = idx_q + byte_idx_t'(1);
                    end
                end
            end

            GAP: begin
                // entry value is nonzero, so terminal count 1 gives i_gap cycles
                if (gap_cnt_q == GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    if (!i_enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HDR;
                        idx_d   = '0;
                        len_d   = clamp_len(i_frame_len);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            DONE: begin
                if (!i_enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            seq_q       <= '0;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign o_tx_valid  = tx_valid;
    assign o_tx_data   = !tx_valid          ? 8'h00 :
                         (state_q == HDR)   ? hdr_byte : idx_q[7:0];
    assign o_tx_last   = is_last;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_test_frame_gen.sv
module tb_eth_test_frame_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [10:0] frame_len;
    logic [15:0] gap;
    logic [31:0] num_frames;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic [31:0] frame_cnt;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] fbuf [0:2047];
    int         f_beats;
    int         f_idle;
    int         f_stall_err;
    int         f_drop_err;
    bit         f_timeout;

    eth_test_frame_gen dut (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .i_enable     (enable),
        .i_frame_len  (frame_len),
        .i_gap        (gap),
        .i_num_frames (num_frames),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .o_tx_last    (tx_last),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] seq);
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        d = 48'hFF_FF_FF_FF_FF_FF;
        s = 48'h00_0A_35_00_00_01;
        t = 16'h88B5;
        if (idx < 6)       return d[47-8*idx -: 8];
        else if (idx < 12) return s[47-8*(idx-6) -: 8];
        else if (idx < 14) return t[15-8*(idx-12) -: 8];
        else if (idx < 18) return seq[31-8*(idx-14) -: 8];
        else               return 8'(idx);
    endfunction

    // Captures one frame from the stream, sampling 1 ns after each falling
    // edge. Optionally randomises ready and drops enable at a given beat.
    task automatic get_frame(input bit rand_ready, input int drop_at, input int budget);
        logic [7:0] pd;
        logic       pl;
        bit         pstall;
        bit         started;
        bit         fin;
        pd = 8'h00; pl = 1'b0; pstall = 0; started = 0; fin = 0;
        f_beats = 0; f_idle = 0; f_stall_err = 0; f_drop_err = 0; f_timeout = 0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            #1;
            if (pstall && (!tx_valid || tx_data !== pd || tx_last !== pl)) f_stall_err++;
            if (tx_valid) begin
                started = 1;
                if (tx_ready) begin
                    if (f_beats < 2048) fbuf[f_beats] = tx_data;
                    if (f_beats == drop_at) enable = 1'b0;
                    f_beats++;
                    if (tx_last) fin = 1;
                end
            end else if (started) begin
                f_drop_err++;
            end else begin
                f_idle++;
            end
            pstall = tx_valid && !tx_ready;
            pd     = tx_data;
            pl     = tx_last;
        end
        if (!fin) f_timeout = 1;
        if (rand_ready) tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int exp_len, input logic [31:0] exp_seq);
        int nb;
        nb = 0;
        for (int i = 0; i < f_beats && i < 2048; i++) begin
            if (fbuf[i] !== exp_byte(i, exp_seq)) nb++;
        end
        check_val({tag, " timeout"}, 64'(f_timeout), 64'd0);
        check_val({tag, " beats"}, 64'(f_beats), 64'(exp_len));
        check_val({tag, " bytes"}, 64'(nb), 64'd0);
        check_val({tag, " stall hold"}, 64'(f_stall_err), 64'd0);
        check_val({tag, " valid gap"}, 64'(f_drop_err), 64'd0);
    endtask

    initial begin
        int vcount;
        rst_n      = 1'b0;
        enable     = 1'b0;
        frame_len  = 11'd64;
        gap        = 16'd12;
        num_frames = 32'd3;
        tx_ready   = 1'b1;

        #20;
        check_val("rst valid", 64'(tx_valid), 64'd0);
        check_val("rst last", 64'(tx_last), 64'd0);
        check_val("rst data", 64'(tx_data), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst done", 64'(done), 64'd0);
        check_val("rst cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("idle valid", 64'(tx_valid), 64'd0);

        // three 64-byte frames, gap 12
        enable = 1'b1;
        get_frame(0, -1, 200);
        check_frame("t1 f0", 64, 32'd0);
        check_val("t1 latency", 64'(f_idle), 64'd0);
        get_frame(0, -1, 200);
        check_frame("t1 f1", 64, 32'd1);
        check_val("t1 gap1", 64'(f_idle), 64'd12);
        get_frame(0, -1, 200);
        check_frame("t1 f2", 64, 32'd2);
        check_val("t1 gap2", 64'(f_idle), 64'd12);
        @(negedge clk); #1;
        check_val("t1 done", 64'(done), 64'd1);
        check_val("t1 cnt", 64'(frame_cnt), 64'd3);
        check_val("t1 done valid", 64'(tx_valid), 64'd0);
        enable = 1'b0;
        @(negedge clk); #1;
        check_val("t1 done clr", 64'(done), 64'd0);
        check_val("t1 idle busy", 64'(busy), 64'd0);
        check_val("t1 cnt hold", 64'(frame_cnt), 64'd3);

        // length clamps
        frame_len  = 11'd20;
        num_frames = 32'd1;
        gap        = 16'd0;
        enable     = 1'b1;
        get_frame(0, -1, 200);
        check_frame("t2 min", 60, 32'd0);
        @(negedge clk); #1;
        check_val("t2 min done", 64'(done), 64'd1);
        check_val("t2 min cnt", 64'(frame_cnt), 64'd1);
        enable = 1'b0;
        @(negedge clk);
        frame_len = 11'd2000;
        enable    = 1'b1;
        get_frame(0, -1, 3000);
        check_frame("t2 max", 1514, 32'd0);
        @(negedge clk); #1;
        check_val("t2 max done", 64'(done), 64'd1);
        enable = 1'b0;
        @(negedge clk);

        // random backpressure
        frame_len = 11'd100;
        gap       = 16'd5;
        enable    = 1'b1;
        get_frame(1, -1, 2000);
        check_frame("t3 rdy", 100, 32'd0);
        check_val("t3 byte50", 64'(fbuf[50]), 64'h32);
        @(negedge clk); #1;
        check_val("t3 done", 64'(done), 64'd1);
        enable = 1'b0;
        @(negedge clk);

        // continuous back-to-back
        frame_len  = 11'd64;
        gap        = 16'd0;
        num_frames = 32'd0;
        enable     = 1'b1;
        get_frame(0, -1, 200);
        check_frame("t4 f0", 64, 32'd0);
        get_frame(0, -1, 200);
        check_frame("t4 f1", 64, 32'd1);
        check_val("t4 b2b idle", 64'(f_idle), 64'd0);
        check_val("t4 b2b byte0", 64'(fbuf[0]), 64'hFF);
        check_val("t4 cnt", 64'(frame_cnt), 64'd1);

        // enable drop mid-frame
        get_frame(0, 30, 200);
        check_frame("t5 drop", 64, 32'd2);
        @(negedge clk); #1;
        check_val("t5 valid", 64'(tx_valid), 64'd0);
        check_val("t5 busy", 64'(busy), 64'd0);
        check_val("t5 cnt", 64'(frame_cnt), 64'd3);
        vcount = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (tx_valid) vcount++;
        end
        check_val("t5 no valid", 64'(vcount), 64'd0);

        // async reset mid-payload
        gap    = 16'd3;
        enable = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        check_val("t6 pre valid", 64'(tx_valid), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6 rst valid", 64'(tx_valid), 64'd0);
        check_val("t6 rst last", 64'(tx_last), 64'd0);
        check_val("t6 rst busy", 64'(busy), 64'd0);
        check_val("t6 rst cnt", 64'(frame_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        get_frame(0, -1, 200);
        check_frame("t6 restart", 64, 32'd0);
        check_val("t6 latency", 64'(f_idle), 64'd0);
        enable = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
